// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its downstream buffering.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  localparam int COEF_W   = 9;

  // Ceiling log2 for sizing address and pointer fields; clog2(1) = 0.
  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_buf_ram.sv
// Sample storage: synchronous write, asynchronous read, no reset on the array.
module fir_buf_ram
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                      CLK,
  input  logic                      WE,
  input  logic [clog2(DEPTH)-1:0]   WADDR,
  input  logic [DATA_W-1:0]         WDATA,
  input  logic [clog2(DEPTH)-1:0]   RADDR,
  output logic [DATA_W-1:0]         RDATA
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the sample at the addressed slot.
  always_ff @(posedge CLK) begin
    if (WE) mem_q[WADDR] <= WDATA;
  end

  assign RDATA = mem_q[RADDR];

endmodule

// File: rtl/fir_out_buffer.sv
// Show-ahead output FIFO behind myfir: absorbs filter samples without
// backpressure, presents them on valid/ready and tracks dropped samples.
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int CNT_W     = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    VIN,
  input  logic [DATA_W-1:0]       DIN,
  input  logic                    READY,
  input  logic                    CLR_OVF,
  output logic                    VOUT,
  output logic [DATA_W-1:0]       DOUT,
  output logic [clog2(DEPTH):0]   COUNT,
  output logic                    FULL,
  output logic                    ALMOST_FULL,
  output logic                    OVF,
  output logic [CNT_W-1:0]        DROP_CNT
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic [CNT_W-1:0]  drop_q,   drop_d;
  logic              full, nonempty, pop, push, drop;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  drop_base;

  assign full     = (count_q == DEPTH_C);
  assign nonempty = (count_q != '0);
  assign pop      = nonempty & READY;
  assign push     = VIN & (~full | pop);
  assign drop     = VIN & full & ~pop;

  fir_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .CLK   (CLK),
    .WE    (push & ~RST),
    .WADDR (wr_ptr_q[AW-1:0]),
    .WDATA (DIN),
    .RADDR (rd_ptr_q[AW-1:0]),
    .RDATA (rdata)
  );

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + PW'(1);
    else if (pop && !push) count_d = count_q - PW'(1);
    // Clear is applied before counting so a same-cycle drop survives it.
    drop_base = CLR_OVF ? '0 : drop_q;
    drop_d    = drop_base;
    if (drop && (drop_base != '1)) drop_d = drop_base + CNT_W'(1);
    ovf_d = (ovf_q & ~CLR_OVF) | drop;
  end

  // State registers with synchronous reset overriding any push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign VOUT        = nonempty;
  assign DOUT        = nonempty ? rdata : '0;
  assign COUNT       = count_q;
  assign FULL        = full;
  assign ALMOST_FULL = (count_q >= AF_C);
  assign OVF         = ovf_q;
  assign DROP_CNT    = drop_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer with hand-computed expectations.
module tb_fir_out_buffer;

  logic        clk;
  logic        rst;
  logic        vin;
  logic [15:0] din;
  logic        ready;
  logic        clr_ovf;
  logic        vout;
  logic [15:0] dout;
  logic [3:0]  count;
  logic        full;
  logic        almost_full;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int total;
  int bad;

  fir_out_buffer #(
    .DATA_W    (16),
    .DEPTH     (8),
    .AF_MARGIN (2),
    .CNT_W     (8)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .VIN         (vin),
    .DIN         (din),
    .READY       (ready),
    .CLR_OVF     (clr_ovf),
    .VOUT        (vout),
    .DOUT        (dout),
    .COUNT       (count),
    .FULL        (full),
    .ALMOST_FULL (almost_full),
    .OVF         (ovf),
    .DROP_CNT    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    vin     = 1'b1;
    din     = 16'h0055;
    ready   = 1'b0;
    clr_ovf = 1'b0;

    // 1. reset held with VIN=1
    repeat (3) cyc();
    chk("rst_vout", vout, 0);
    chk("rst_dout", dout, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    rst = 1'b0;
    vin = 1'b0;
    cyc();
    chk("idle_count", count, 0);

    // 2. three pushes then drain in order
    for (int i = 1; i <= 3; i++) begin
      vin = 1'b1;
      din = 16'(i);
      cyc();
      if (i == 1) begin
        chk("lat_vout", vout, 1);
        chk("lat_dout", dout, 16'h0001);
      end
    end
    vin = 1'b0;
    chk("p3_count", count, 3);
    chk("p3_vout", vout, 1);
    chk("p3_dout", dout, 16'h0001);
    ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("drain3_dout", dout, 32'(i));
      cyc();
    end
    chk("drain3_count", count, 0);
    chk("drain3_vout", vout, 0);
    chk("drain3_dout0", dout, 0);
    cyc();
    chk("ready_empty_count", count, 0);
    ready = 1'b0;

    // 3. ten pushes into eight slots
    for (int i = 0; i < 10; i++) begin
      vin = 1'b1;
      din = 16'h0010 + 16'(i);
      cyc();
      chk("fill_count", count, (i + 1 > 8) ? 8 : i + 1);
      chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
    end
    vin = 1'b0;
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    chk("ovf_flag", ovf, 1);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head", dout, 16'h0010);

    // 4. push while full with simultaneous pop
    vin   = 1'b1;
    din   = 16'h00AA;
    ready = 1'b1;
    cyc();
    vin = 1'b0;
    chk("fp_count", count, 8);
    chk("fp_full", full, 1);
    chk("fp_drop", drop_cnt, 2);
    chk("fp_head", dout, 16'h0011);
    for (int i = 1; i <= 7; i++) begin
      chk("drain8_dout", dout, 32'h10 + 32'(i));
      cyc();
    end
    chk("wrap_dout", dout, 16'h00AA);
    cyc();
    chk("wrap_empty_count", count, 0);
    chk("wrap_empty_vout", vout, 0);
    ready   = 1'b0;
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_drop", drop_cnt, 0);

    // 5. streaming with READY held high
    ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      vin = 1'b1;
      din = 16'h0100 + 16'(i);
      cyc();
      chk("stream_dout", dout, 32'h100 + 32'(i));
      chk("stream_count", count, 1);
      chk("stream_ovf", ovf, 0);
    end
    vin = 1'b0;
    cyc();
    chk("stream_end_count", count, 0);

    // 6a. reset mid-operation
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vin = 1'b1;
      din = 16'h0020 + 16'(i);
      cyc();
    end
    chk("pre_rst_count", count, 5);
    rst   = 1'b1;
    ready = 1'b1;
    cyc();
    chk("midrst_count", count, 0);
    chk("midrst_vout", vout, 0);
    chk("midrst_dout", dout, 0);
    rst   = 1'b0;
    vin   = 1'b0;
    ready = 1'b0;

    // 6b. clear coinciding with a drop, then saturation
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1;
      din = 16'h0030 + 16'(i);
      cyc();
    end
    chk("refill_full", full, 1);
    cyc();
    chk("drop1_cnt", drop_cnt, 1);
    din = 16'h0040;
    cyc();
    chk("drop2_cnt", drop_cnt, 2);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("clrdrop_ovf", ovf, 1);
    chk("clrdrop_cnt", drop_cnt, 1);
    repeat (300) cyc();
    vin = 1'b0;
    chk("sat_cnt", drop_cnt, 8'hFF);
    chk("sat_ovf", ovf, 1);
    chk("sat_count", count, 8);
    chk("sat_head", dout, 16'h0030);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("clr2_cnt", drop_cnt, 0);
    chk("clr2_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
